// File: rtl/segre_history_file_pkg.sv
// Shared types and sizes for the segre history file.
// Holds the FSM state enum, the per-entry record and the bundle of
// recovery/exception outputs driven towards the core.
package segre_history_file_pkg;

    localparam int unsigned HF_SIZE   = 8;
    localparam int unsigned HF_PTR    = $clog2(HF_SIZE);
    localparam int unsigned REG_SIZE  = 5;
    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned ADDR_SIZE = 32;

    typedef enum logic {
        HF_RUN,
        HF_RECOVER
    } hf_fsm_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic                 exc;
        logic                 rf_we;
        logic [REG_SIZE-1:0]  dest_reg;
        logic [WORD_SIZE-1:0] old_value;
        logic [ADDR_SIZE-1:0] pc;
    } hf_entry_t;

    // Status and recovery bundle presented to the rest of the core.
    typedef struct packed {
        logic [HF_PTR-1:0]    instr_id;
        logic                 full;
        logic                 empty;
        logic                 retire;
        logic                 recovering;
        logic                 rec_we;
        logic [REG_SIZE-1:0]  rec_reg;
        logic [WORD_SIZE-1:0] rec_value;
        logic                 exc;
        logic [ADDR_SIZE-1:0] exc_pc;
    } core_hf_t;

endpackage

// File: rtl/segre_history_file.sv
// In-order history file for precise memory exceptions.
// ID allocates one entry per issued instruction (dest reg, its old value, PC);
// EX/MEM/RVM report completion by id; the head retires in order. A faulting
// head starts a youngest-to-oldest register-file rollback, one entry per
// cycle, followed by a one-cycle exc_o pulse carrying the faulting PC.
// Ports:
//   clk_i, rsn_i                      clock, async active-low reset
//   new_entry_i, rf_we_i, dest_reg_i,
//   old_value_i, pc_i, instr_id_o     allocation from ID (id = tail)
//   *_complete_i, *_complete_id_i,
//   mem_exc_i                         completion reports
//   full_o, empty_o, retire_o         occupancy / retirement
//   recovering_o, rec_we_o, rec_reg_o,
//   rec_value_o                       register-file restore port
//   exc_o, exc_pc_o                   exception to the front end
//   retired_cnt_o, recovery_cnt_o     performance counters
// Optional: define HF_PERF_EN to instantiate the counters (tied to 0 otherwise).
module segre_history_file
    import segre_history_file_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 new_entry_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  dest_reg_i,
    input  logic [WORD_SIZE-1:0] old_value_i,
    input  logic [ADDR_SIZE-1:0] pc_i,
    output logic [HF_PTR-1:0]    instr_id_o,
    input  logic                 ex_complete_i,
    input  logic [HF_PTR-1:0]    ex_complete_id_i,
    input  logic                 mem_complete_i,
    input  logic [HF_PTR-1:0]    mem_complete_id_i,
    input  logic                 mem_exc_i,
    input  logic                 rvm_complete_i,
    input  logic [HF_PTR-1:0]    rvm_complete_id_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 retire_o,
    output logic                 recovering_o,
    output logic                 rec_we_o,
    output logic [REG_SIZE-1:0]  rec_reg_o,
    output logic [WORD_SIZE-1:0] rec_value_o,
    output logic                 exc_o,
    output logic [ADDR_SIZE-1:0] exc_pc_o,
    output logic [31:0]          retired_cnt_o,
    output logic [31:0]          recovery_cnt_o
);

    localparam logic [HF_PTR-1:0] PTR_ONE  = HF_PTR'(1);
    localparam logic [HF_PTR:0]   CNT_ONE  = (HF_PTR + 1)'(1);
    localparam logic [HF_PTR:0]   CNT_FULL = (HF_PTR + 1)'(HF_SIZE);

    hf_entry_t            r_entries [HF_SIZE];
    logic [HF_PTR-1:0]    r_head;
    logic [HF_PTR-1:0]    r_tail;
    logic [HF_PTR:0]      r_count;
    logic [HF_PTR-1:0]    r_rec_ptr;
    hf_fsm_state_e        r_state;
    logic                 r_exc;
    logic [ADDR_SIZE-1:0] r_exc_pc;

    logic                 w_run;
    logic                 w_full;
    logic                 w_head_done;
    logic                 w_retire;
    logic                 w_fault;
    logic                 w_alloc;
    core_hf_t             w_hf;

    assign w_run       = (r_state == HF_RUN);
    assign w_full      = (r_count == CNT_FULL);
    // Head status comes from registered flags only, so a completion can
    // retire at the earliest one cycle after it is reported.
    assign w_head_done = r_entries[r_head].valid && r_entries[r_head].complete;
    assign w_retire    = w_run && w_head_done && !r_entries[r_head].exc;
    assign w_fault     = w_run && w_head_done && r_entries[r_head].exc;
    // No allocation in the trigger cycle: the rollback pointer is taken from
    // the current tail and the new instruction is squashed anyway.
    assign w_alloc     = w_run && new_entry_i && !w_full && !w_fault;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int unsigned i = 0; i < HF_SIZE; i++) begin
                r_entries[i] <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_rec_ptr <= '0;
            r_state   <= HF_RUN;
            r_exc     <= 1'b0;
            r_exc_pc  <= '0;
        end else begin
            r_exc <= 1'b0;
            case (r_state)
                HF_RUN: begin
                    if (ex_complete_i && r_entries[ex_complete_id_i].valid) begin
                        r_entries[ex_complete_id_i].complete <= 1'b1;
                    end
                    if (mem_complete_i && r_entries[mem_complete_id_i].valid) begin
                        r_entries[mem_complete_id_i].complete <= 1'b1;
                        if (mem_exc_i) begin
                            r_entries[mem_complete_id_i].exc <= 1'b1;
                        end
                    end
                    if (rvm_complete_i && r_entries[rvm_complete_id_i].valid) begin
                        r_entries[rvm_complete_id_i].complete <= 1'b1;
                    end
                    // Allocation targets an invalid slot, so it never collides
                    // with a completion above.
                    if (w_alloc) begin
                        r_entries[r_tail] <= '{valid:     1'b1,
                                               complete:  1'b0,
                                               exc:       1'b0,
                                               rf_we:     rf_we_i,
                                               dest_reg:  dest_reg_i,
                                               old_value: old_value_i,
                                               pc:        pc_i};
                        r_tail <= r_tail + PTR_ONE;
                    end
                    if (w_retire) begin
                        r_entries[r_head].valid <= 1'b0;
                        r_head <= r_head + PTR_ONE;
                    end
                    case ({w_alloc, w_retire})
                        2'b10:   r_count <= r_count + CNT_ONE;
                        2'b01:   r_count <= r_count - CNT_ONE;
                        default: r_count <= r_count;
                    endcase
                    if (w_fault) begin
                        r_state   <= HF_RECOVER;
                        r_exc_pc  <= r_entries[r_head].pc;
                        r_rec_ptr <= r_tail - PTR_ONE;
                    end
                end
                HF_RECOVER: begin
                    r_entries[r_rec_ptr].valid <= 1'b0;
                    r_rec_ptr <= r_rec_ptr - PTR_ONE;
                    // The head is the faulting entry and the last one undone.
                    if (r_rec_ptr == r_head) begin
                        r_state <= HF_RUN;
                        r_head  <= '0;
                        r_tail  <= '0;
                        r_count <= '0;
                        r_exc   <= 1'b1;
                    end
                end
                default: r_state <= HF_RUN;
            endcase
        end
    end

    always_comb begin
        w_hf            = '0;
        w_hf.instr_id   = r_tail;
        w_hf.full       = w_full;
        w_hf.empty      = (r_count == '0);
        w_hf.retire     = w_retire;
        w_hf.recovering = !w_run;
        w_hf.exc        = r_exc;
        w_hf.exc_pc     = r_exc_pc;
        if (!w_run) begin
            w_hf.rec_we    = r_entries[r_rec_ptr].rf_we;
            w_hf.rec_reg   = r_entries[r_rec_ptr].dest_reg;
            w_hf.rec_value = r_entries[r_rec_ptr].old_value;
        end
    end

    assign instr_id_o   = w_hf.instr_id;
    assign full_o       = w_hf.full;
    assign empty_o      = w_hf.empty;
    assign retire_o     = w_hf.retire;
    assign recovering_o = w_hf.recovering;
    assign rec_we_o     = w_hf.rec_we;
    assign rec_reg_o    = w_hf.rec_reg;
    assign rec_value_o  = w_hf.rec_value;
    assign exc_o        = w_hf.exc;
    assign exc_pc_o     = w_hf.exc_pc;

`ifdef HF_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_recovery_cnt;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_retired_cnt  <= '0;
            r_recovery_cnt <= '0;
        end else begin
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (r_exc) begin
                r_recovery_cnt <= r_recovery_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt_o  = r_retired_cnt;
    assign recovery_cnt_o = r_recovery_cnt;
`else
    assign retired_cnt_o  = '0;
    assign recovery_cnt_o = '0;
`endif

endmodule

// File: tb/tb_segre_history_file.sv
// Directed testbench for segre_history_file: per-cycle vector tables for the
// in-order, full/wrap and multi-completion scenarios, plus hand-written
// sequences for rollback and reset during rollback.
module tb_segre_history_file;
    import segre_history_file_pkg::*;

    logic                 clk;
    logic                 rsn;
    logic                 new_entry;
    logic                 rf_we;
    logic [REG_SIZE-1:0]  dest_reg;
    logic [WORD_SIZE-1:0] old_value;
    logic [ADDR_SIZE-1:0] pc;
    logic [HF_PTR-1:0]    instr_id;
    logic                 ex_c;
    logic [HF_PTR-1:0]    ex_id;
    logic                 mem_c;
    logic [HF_PTR-1:0]    mem_id;
    logic                 mem_exc;
    logic                 rvm_c;
    logic [HF_PTR-1:0]    rvm_id;
    logic                 full;
    logic                 empty;
    logic                 retire;
    logic                 recovering;
    logic                 rec_we;
    logic [REG_SIZE-1:0]  rec_reg;
    logic [WORD_SIZE-1:0] rec_value;
    logic                 exc;
    logic [ADDR_SIZE-1:0] exc_pc;
    logic [31:0]          retired_cnt;
    logic [31:0]          recovery_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    segre_history_file u_dut (
        .clk_i             (clk),
        .rsn_i             (rsn),
        .new_entry_i       (new_entry),
        .rf_we_i           (rf_we),
        .dest_reg_i        (dest_reg),
        .old_value_i       (old_value),
        .pc_i              (pc),
        .instr_id_o        (instr_id),
        .ex_complete_i     (ex_c),
        .ex_complete_id_i  (ex_id),
        .mem_complete_i    (mem_c),
        .mem_complete_id_i (mem_id),
        .mem_exc_i         (mem_exc),
        .rvm_complete_i    (rvm_c),
        .rvm_complete_id_i (rvm_id),
        .full_o            (full),
        .empty_o           (empty),
        .retire_o          (retire),
        .recovering_o      (recovering),
        .rec_we_o          (rec_we),
        .rec_reg_o         (rec_reg),
        .rec_value_o       (rec_value),
        .exc_o             (exc),
        .exc_pc_o          (exc_pc),
        .retired_cnt_o     (retired_cnt),
        .recovery_cnt_o    (recovery_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              ne;
        logic              exv;
        logic [HF_PTR-1:0] exid;
        logic              mv;
        logic [HF_PTR-1:0] mid;
        logic              rv;
        logic [HF_PTR-1:0] rid;
        logic [HF_PTR-1:0] e_id;
        logic              e_full;
        logic              e_empty;
        logic              e_ret;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ne, logic exv, int exid, logic mv, int mid,
                                logic rv, int rid, int e_id, logic e_full,
                                logic e_empty, logic e_ret);
        vec_t v;
        v.ne = ne; v.exv = exv; v.exid = HF_PTR'(exid);
        v.mv = mv; v.mid = HF_PTR'(mid); v.rv = rv; v.rid = HF_PTR'(rid);
        v.e_id = HF_PTR'(e_id); v.e_full = e_full; v.e_empty = e_empty; v.e_ret = e_ret;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        new_entry = 1'b0; rf_we = 1'b0; dest_reg = '0; old_value = '0; pc = '0;
        ex_c = 1'b0; ex_id = '0; mem_c = 1'b0; mem_id = '0; mem_exc = 1'b0;
        rvm_c = 1'b0; rvm_id = '0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rsn = 1'b0;
        repeat (2) @(negedge clk);
        rsn = 1'b1;
    endtask

    // One vector per cycle: drive at the falling edge, check just after.
    task automatic run_vectors(string tag);
        for (int i = 0; i < vq.size(); i++) begin
            idle_inputs();
            new_entry = vq[i].ne;
            rf_we     = 1'b1;
            dest_reg  = REG_SIZE'(i + 1);
            old_value = WORD_SIZE'(32'h1000 + i);
            pc        = ADDR_SIZE'(32'h400 + 4 * i);
            ex_c  = vq[i].exv; ex_id  = vq[i].exid;
            mem_c = vq[i].mv;  mem_id = vq[i].mid;
            rvm_c = vq[i].rv;  rvm_id = vq[i].rid;
            #1;
            check($sformatf("%s[%0d].instr_id", tag, i), 64'(instr_id), 64'(vq[i].e_id));
            check($sformatf("%s[%0d].full", tag, i), 64'(full), 64'(vq[i].e_full));
            check($sformatf("%s[%0d].empty", tag, i), 64'(empty), 64'(vq[i].e_empty));
            check($sformatf("%s[%0d].retire", tag, i), 64'(retire), 64'(vq[i].e_ret));
            @(negedge clk);
        end
        idle_inputs();
        vq.delete();
    endtask

    task automatic alloc(int rd, int val, int pcv);
        idle_inputs();
        new_entry = 1'b1; rf_we = 1'b1;
        dest_reg = REG_SIZE'(rd); old_value = WORD_SIZE'(val); pc = ADDR_SIZE'(pcv);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic fault_id0();
        mem_c = 1'b1; mem_id = '0; mem_exc = 1'b1;
        #1;
        check("fault.report_no_retire", 64'(retire), 64'(0));
        @(negedge clk);
        idle_inputs();
        #1;
        check("fault.trigger_no_retire", 64'(retire), 64'(0));
        check("fault.trigger_not_recovering", 64'(recovering), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        do_reset();

        // In-order retirement with out-of-order completion.
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 0, 0, 0, 0, 3, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 3, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0));
        run_vectors("inorder");
`ifdef HF_PERF_EN
        check("perf.retired_after_inorder", 64'(retired_cnt), 64'(3));
`else
        check("perf.retired_tied", 64'(retired_cnt), 64'(0));
`endif

        // Fill, dropped ninth allocation, retire one, wrap to id 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, i, 0, i == 0, 0));
        end
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        run_vectors("full");

        // Triple completions in one cycle; allocate and retire together.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, i, 0, i == 0, 0));
        end
        vq.push_back(mk(0, 1, 0, 1, 1, 1, 2, 6, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 1, 4, 1, 5, 6, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1));
        end
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0));
        vq.push_back(mk(0, 1, 6, 0, 0, 0, 0, 7, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0));
        run_vectors("multi");

        // Rollback: youngest first, then one exc_o cycle.
        do_reset();
        alloc(5, 32'h11, 32'h100);
        alloc(6, 32'h22, 32'h104);
        alloc(5, 32'hAA, 32'h108);
        fault_id0();
        new_entry = 1'b1; ex_c = 1'b1; ex_id = HF_PTR'(1);
        #1;
        check("rb0.recovering", 64'(recovering), 64'(1));
        check("rb0.rec_we", 64'(rec_we), 64'(1));
        check("rb0.rec_reg", 64'(rec_reg), 64'(5));
        check("rb0.rec_value", 64'(rec_value), 64'(32'hAA));
        @(negedge clk);
        #1;
        check("rb1.rec_reg", 64'(rec_reg), 64'(6));
        check("rb1.rec_value", 64'(rec_value), 64'(32'h22));
        check("rb1.exc", 64'(exc), 64'(0));
        @(negedge clk);
        #1;
        check("rb2.rec_reg", 64'(rec_reg), 64'(5));
        check("rb2.rec_value", 64'(rec_value), 64'(32'h11));
        check("rb2.rec_we", 64'(rec_we), 64'(1));
        @(negedge clk);
        idle_inputs();
        #1;
        check("rb.exc", 64'(exc), 64'(1));
        check("rb.exc_pc", 64'(exc_pc), 64'(32'h100));
        check("rb.empty", 64'(empty), 64'(1));
        check("rb.recovering_done", 64'(recovering), 64'(0));
        check("rb.rec_we_done", 64'(rec_we), 64'(0));
        check("rb.instr_id", 64'(instr_id), 64'(0));
        @(negedge clk);
        #1;
        check("rb.exc_single_pulse", 64'(exc), 64'(0));
`ifdef HF_PERF_EN
        check("perf.recovery_after_rb", 64'(recovery_cnt), 64'(1));
`else
        check("perf.recovery_tied", 64'(recovery_cnt), 64'(0));
`endif
        @(negedge clk);

        // Reset in the middle of a rollback: no exception afterwards.
        do_reset();
        alloc(7, 32'h1, 32'h200);
        alloc(8, 32'h2, 32'h204);
        fault_id0();
        #1;
        check("rst.recovering_before", 64'(recovering), 64'(1));
        #1;
        rsn = 1'b0;
        #1;
        check("rst.recovering", 64'(recovering), 64'(0));
        check("rst.empty", 64'(empty), 64'(1));
        check("rst.rec_we", 64'(rec_we), 64'(0));
        @(negedge clk);
        rsn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rst.no_exc[%0d]", i), 64'(exc), 64'(0));
            check($sformatf("rst.idle_recovering[%0d]", i), 64'(recovering), 64'(0));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
